pin_entry_tx: RTL and testbench

//  Transmit side of the digit/submit PIN protocol: serialises a stored PIN

---
 rtl/pin_entry_tx.sv | 147 ++++++++++++++
 tb/tb_pin_entry_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pin_entry_tx.sv
// pin_entry_tx: serialises a stored PIN into 2-bit digit + submit strobes,
// waits for the checker's verdict, counts consecutive failures and locks out
// after MAX_TRIES failed attempts until unlock is asserted.
module pin_entry_tx #(
  parameter int NUM_DIGITS  = 4,
  parameter int GAP         = 4,
  parameter int RES_TIMEOUT = 64,
  parameter int MAX_TRIES   = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [2*NUM_DIGITS-1:0] pin,
  input  logic                    unlock,
  input  logic                    correct,
  input  logic                    incorrect,
  output logic [1:0]              digit,
  output logic                    submit,
  output logic                    busy,
  output logic                    pass,
  output logic                    fail,
  output logic                    timeout,
  output logic                    locked,
  output logic [2:0]              tries
);

  localparam int PW = 2*NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TW = $clog2(RES_TIMEOUT) + 1;

  // Terminal values of the hold counter, digit index and result timer
  localparam logic [3:0]    GLAST = 4'(GAP - 2);
  localparam logic [IW-1:0] ILAST = IW'(NUM_DIGITS - 1);
  localparam logic [TW-1:0] TLAST = TW'(RES_TIMEOUT - 1);
  localparam logic [2:0]    MAXT  = 3'(MAX_TRIES);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    HOLD     = 3'd2,
    WAIT_RES = 3'd3,
    LOCKED   = 3'd4
  } state_t;

  state_t        state;
  logic [PW-1:0] shreg;   // digits not yet presented, next one at the MSBs
  logic [IW-1:0] idx;
  logic [3:0]    gcnt;
  logic [TW-1:0] timer;
  logic [2:0]    tries_inc;

  // A same-cycle unlock clears the count before a failure is added to it
  assign tries_inc = (unlock ? 3'd0 : tries) + 3'd1;

  // Protocol FSM; every output is a register updated here
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shreg   <= '0;
      idx     <= '0;
      gcnt    <= '0;
      timer   <= '0;
      digit   <= 2'd0;
      submit  <= 1'b0;
      busy    <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
      timeout <= 1'b0;
      locked  <= 1'b0;
      tries   <= 3'd0;
    end else begin
      submit  <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
      timeout <= 1'b0;
      if (unlock) tries <= 3'd0;
      case (state)
        IDLE: begin
          digit <= 2'd0;
          if (start) begin
            digit  <= pin[PW-1 -: 2];
            shreg  <= pin << 2;
            submit <= 1'b1;
            busy   <= 1'b1;
            idx    <= '0;
            state  <= SEND;
          end
        end
        SEND: begin
          gcnt  <= 4'd0;
          state <= HOLD;
        end
        HOLD: begin
          if (gcnt == GLAST) begin
            if (idx != ILAST) begin
              idx    <= idx + 1'b1;
              digit  <= shreg[PW-1 -: 2];
              shreg  <= shreg << 2;
              submit <= 1'b1;
              state  <= SEND;
            end else begin
              digit <= 2'd0;
              timer <= '0;
              state <= WAIT_RES;
            end
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        WAIT_RES: begin
          timer <= timer + 1'b1;
          if (correct) begin
            pass  <= 1'b1;
            tries <= 3'd0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (incorrect || timer == TLAST) begin
            fail    <= 1'b1;
            timeout <= !incorrect;
            tries   <= tries_inc;
            busy    <= 1'b0;
            if (tries_inc == MAXT) begin
              locked <= 1'b1;
              state  <= LOCKED;
            end else begin
              state <= IDLE;
            end
          end
        end
        LOCKED: begin
          digit <= 2'd0;
          if (unlock) begin
            locked <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          digit  <= 2'd0;
          busy   <= 1'b0;
          locked <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pin_entry_tx.sv
// tb_pin_entry_tx: directed scenarios plus random traffic, checked every
// cycle against a timeline model of the PIN transmit protocol.
module tb_pin_entry_tx;

  localparam int ND  = 4;
  localparam int GAP = 4;
  localparam int RT  = 64;
  localparam int MT  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, unlock, correct, incorrect;
  logic [7:0] pin;
  logic [1:0] digit;
  logic       submit, busy, pass, fail, timeout, locked;
  logic [2:0] tries;

  pin_entry_tx #(.NUM_DIGITS(ND), .GAP(GAP), .RES_TIMEOUT(RT), .MAX_TRIES(MT)) dut (
    .clk(clk), .reset(reset), .start(start), .pin(pin), .unlock(unlock),
    .correct(correct), .incorrect(incorrect), .digit(digit), .submit(submit),
    .busy(busy), .pass(pass), .fail(fail), .timeout(timeout), .locked(locked),
    .tries(tries)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;
  int c    = 0;

  // model: an attempt is a start cycle plus the PIN; everything else follows
  // from elapsed time since that start
  bit         m_act, m_lock, e_pass, e_fail, e_to;
  int         ts, m_tries;
  logic [7:0] apin;

  int sub_c[$];
  int sub_d[$];
  int pass_c, fail_c, to_c;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, c, a, e);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_lock = 0; e_pass = 0; e_fail = 0; e_to = 0;
    ts = 0; m_tries = 0; apin = 0;
  endtask

  task automatic clear_log();
    sub_c.delete(); sub_d.delete();
    pass_c = -1; fail_c = -1; to_c = -1;
  endtask

  // expected outputs for the current cycle, compared against the DUT
  task automatic check_all();
    int k;
    logic [1:0] ed;
    logic es, eb;
    ed = 0; es = 0; eb = 0;
    if (m_act) begin
      k  = c - ts - 1;
      eb = 1;
      if (k < ND*GAP) begin
        es = (k % GAP == 0);
        ed = 2'(apin >> (2*(ND-1-k/GAP)));
      end
    end
    chk("digit",   digit,   ed);
    chk("submit",  submit,  es);
    chk("busy",    busy,    eb);
    chk("pass",    pass,    e_pass);
    chk("fail",    fail,    e_fail);
    chk("timeout", timeout, e_to);
    chk("locked",  locked,  m_lock);
    chk("tries",   tries,   m_tries);
    if (submit) begin sub_c.push_back(c); sub_d.push_back(int'(digit)); end
    if (pass)    pass_c = c;
    if (fail)    fail_c = c;
    if (timeout) to_c   = c;
  endtask

  // advance the model by the inputs present during cycle c
  task automatic model_update();
    int k, w;
    bit was_lock;
    if (!reset) begin model_reset(); return; end
    e_pass = 0; e_fail = 0; e_to = 0;
    was_lock = m_lock;
    if (unlock) begin m_tries = 0; m_lock = 0; end
    if (m_act) begin
      k = c - ts - 1;
      if (k >= ND*GAP) begin
        w = k - ND*GAP;
        if (correct) begin
          e_pass = 1; m_tries = 0; m_act = 0;
        end else if (incorrect || w == RT-1) begin
          e_fail = 1; e_to = !incorrect; m_tries++; m_act = 0;
          if (m_tries == MT) m_lock = 1;
        end
      end
    end else if (!was_lock && start) begin
      m_act = 1; ts = c; apin = pin;
    end
  endtask

  task automatic cyc_step();
    model_update();
    @(negedge clk);
    c++;
    check_all();
  endtask

  task automatic step_to(input int target);
    while (c < target) cyc_step();
  endtask

  task automatic send(input logic [7:0] p);
    pin = p; start = 1; cyc_step(); start = 0;
  endtask

  task automatic chk_seq(input string name, input int n0, input logic [7:0] p);
    logic [7:0] pv;
    pv = p;
    chk({name, "_nsub"}, sub_c.size(), ND);
    for (int i = 0; i < ND; i++) begin
      if (i < sub_c.size()) begin
        chk({name, "_subcyc"}, sub_c[i] - n0, 1 + i*GAP);
        chk({name, "_dig"},    sub_d[i], int'(pv[7-2*i -: 2]));
      end
    end
  endtask

  initial begin
    int n0;
    reset = 0; start = 0; unlock = 0; correct = 0; incorrect = 0; pin = 0;
    model_reset(); clear_log();
    @(negedge clk);
    check_all();
    chk("rst_busy", busy, 0);
    chk("rst_submit", submit, 0);
    chk("rst_tries", tries, 0);
    cyc_step(); cyc_step();
    reset = 1;
    cyc_step(); cyc_step();

    // 1: correct PIN, digits 2,2,1,3 at N+1,+5,+9,+13, pass on a reply at N+20
    clear_log(); n0 = c;
    send(8'b10_10_01_11);
    step_to(n0 + 20);
    correct = 1; cyc_step(); correct = 0;
    cyc_step(); cyc_step();
    chk_seq("t1", n0, 8'b10_10_01_11);
    chk("t1_pass_cyc", pass_c - n0, 21);
    chk("t1_busy", busy, 0);
    chk("t1_tries", tries, 0);

    // 3: silent checker, timeout RES_TIMEOUT cycles after WAIT_RES entry
    clear_log(); n0 = c;
    send(8'h5A);
    step_to(n0 + 85);
    chk("t3_to_cyc", to_c - n0, 17 + RT);
    chk("t3_fail_cyc", fail_c - n0, 17 + RT);
    chk("t3_tries", tries, 1);

    // 5: reset in the second HOLD, then a fresh attempt from digit 0
    clear_log(); n0 = c;
    send(8'b01_10_11_00);
    step_to(n0 + 6);
    reset = 0;
    #1;
    chk("t5_submit", submit, 0);
    chk("t5_digit", digit, 0);
    chk("t5_busy", busy, 0);
    chk("t5_tries", tries, 0);
    model_reset();
    cyc_step(); cyc_step();
    reset = 1;
    cyc_step(); cyc_step();
    clear_log(); n0 = c;
    send(8'b01_10_11_00);
    step_to(n0 + 20);
    chk_seq("t5", n0, 8'b01_10_11_00);
    step_to(n0 + 85);

    // 4: stray start in HOLD and results during SEND are ignored
    clear_log(); n0 = c;
    send(8'b00_01_10_11);
    step_to(n0 + 2);
    pin = 8'hFF; start = 1; cyc_step(); start = 0;
    step_to(n0 + 5);
    correct = 1; incorrect = 1; cyc_step(); correct = 0; incorrect = 0;
    step_to(n0 + 25);
    correct = 1; cyc_step(); correct = 0;
    cyc_step();
    chk_seq("t4", n0, 8'b00_01_10_11);
    chk("t4_pass_cyc", pass_c - n0, 26);
    chk("t4_tries", tries, 0);

    // 2: three rejections lock the block; a further start is dropped
    for (int a = 0; a < MT; a++) begin
      n0 = c;
      send(8'hC6);
      step_to(n0 + 18);
      incorrect = 1; cyc_step(); incorrect = 0;
      cyc_step();
      chk("t2_tries", tries, a + 1);
      chk("t2_locked", locked, (a == MT-1) ? 1 : 0);
    end
    clear_log(); n0 = c;
    send(8'hC6);
    step_to(n0 + 30);
    chk("t2_nsub_locked", sub_c.size(), 0);
    chk("t2_busy_locked", busy, 0);

    // 6: unlock, then correct+incorrect together yields pass
    unlock = 1; cyc_step(); unlock = 0;
    chk("t6_locked", locked, 0);
    chk("t6_tries", tries, 0);
    clear_log(); n0 = c;
    send(8'b10_10_01_11);
    step_to(n0 + 17);
    correct = 1; incorrect = 1; cyc_step(); correct = 0; incorrect = 0;
    cyc_step();
    chk_seq("t6", n0, 8'b10_10_01_11);
    chk("t6_pass_cyc", pass_c - n0, 18);
    chk("t6_fail_seen", fail_c, -1);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom % 8) == 0;
      pin       = 8'($urandom);
      correct   = ($urandom % 40) == 0;
      incorrect = ($urandom % 40) == 0;
      unlock    = ($urandom % 150) == 0;
      cyc_step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
